// File: rtl/weight_row_sequencer.sv
// rtl/weight_row_sequencer.sv - drives the weight-row mux select and streams rows 0..SEL_SIZE-1 over valid/ready
// Optional feature macro: WEIGHT_SEQ_LOOP_EN (adds input Loop to restart a pass without returning to IDLE).
module weight_row_sequencer #(
  parameter int OUT_SIZE = 133,
  parameter int SEL_SIZE = 112,
  parameter int SEL_BIT  = 7
) (
  input  logic                Clk,
  input  logic                Rst_n,
  input  logic                Start,
  output logic [SEL_BIT-1:0]  Select,
  input  logic [OUT_SIZE-1:0] Mux_Out,
  output logic [OUT_SIZE-1:0] Out_Data,
  output logic [SEL_BIT-1:0]  Out_Index,
  output logic                Out_Valid,
  input  logic                Out_Ready,
  output logic                Out_Last,
  output logic                Busy,
`ifdef WEIGHT_SEQ_LOOP_EN
  output logic                Done,
  input  logic                Loop
`else
  output logic                Done
`endif
);

  localparam logic [SEL_BIT-1:0] LP_LAST = SEL_BIT'(SEL_SIZE - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_SEND = 2'd2
  } state_t;

  state_t                r_state;
  logic [SEL_BIT-1:0]    r_select;
  logic [OUT_SIZE-1:0]   r_out_data;
  logic [SEL_BIT-1:0]    r_out_index;
  logic                  r_out_valid;
  logic                  r_out_last;
  logic                  r_busy;
  logic                  r_done;

  logic                  w_handshake;
  logic                  w_capture;
  logic                  w_loop;

  assign w_handshake = r_out_valid && Out_Ready;
  // A row is captured on the settle cycle and on every non-final handshake (zero-bubble streaming).
  assign w_capture   = (r_state == S_LOAD) ||
                       ((r_state == S_SEND) && w_handshake && !r_out_last);

`ifdef WEIGHT_SEQ_LOOP_EN
  assign w_loop = Loop;
`else
  assign w_loop = 1'b0;
`endif

  // Single FSM: pass control, row capture and all registered outputs.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state     <= S_IDLE;
      r_select    <= '0;
      r_out_data  <= '0;
      r_out_index <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;

      if (w_capture) begin
        r_out_data  <= Mux_Out;
        r_out_index <= r_select;
        r_out_last  <= (r_select == LP_LAST);
        r_out_valid <= 1'b1;
        if (r_select < LP_LAST) begin
          r_select <= r_select + 1'b1;
        end
      end

      case (r_state)
        S_IDLE: begin
          // A Start coinciding with the Done pulse belongs to the pass just finished, so it is dropped.
          if (Start && !r_done) begin
            r_select <= '0;
            r_busy   <= 1'b1;
            r_state  <= S_LOAD;
          end
        end
        S_LOAD: begin
          r_state <= S_SEND;
        end
        S_SEND: begin
          if (w_handshake && r_out_last) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_select    <= '0;
            r_done      <= 1'b1;
            if (w_loop) begin
              r_state <= S_LOAD;
            end else begin
              r_busy  <= 1'b0;
              r_state <= S_IDLE;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign Select    = r_select;
  assign Out_Data  = r_out_data;
  assign Out_Index = r_out_index;
  assign Out_Valid = r_out_valid;
  assign Out_Last  = r_out_last;
  assign Busy      = r_busy;
  assign Done      = r_done;

endmodule

// File: tb/tb_weight_row_sequencer.sv
// tb/tb_weight_row_sequencer.sv - directed self-checking bench for weight_row_sequencer
module tb_weight_row_sequencer;

  localparam int OUT_SIZE = 133;
  localparam int SEL_SIZE = 112;
  localparam int SEL_BIT  = 7;

  logic                Clk = 1'b0;
  logic                Rst_n;
  logic                Start;
  logic [SEL_BIT-1:0]  Select;
  logic [OUT_SIZE-1:0] Mux_Out;
  logic [OUT_SIZE-1:0] Out_Data;
  logic [SEL_BIT-1:0]  Out_Index;
  logic                Out_Valid;
  logic                Out_Ready;
  logic                Out_Last;
  logic                Busy;
  logic                Done;
`ifdef WEIGHT_SEQ_LOOP_EN
  logic                Loop;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int exp_row;
  int done_cnt;
  int cyc;
  logic                stall_prev;
  logic [OUT_SIZE-1:0] held_data;
  logic [SEL_BIT-1:0]  held_index;

  always #5 Clk = ~Clk;

  // Mux model: row i is OUT_SIZE/SEL_BIT copies of i, zero-padded at the top.
  function automatic logic [OUT_SIZE-1:0] mux_row(input int i);
    logic [OUT_SIZE-1:0] r;
    r = '0;
    for (int k = 0; k < OUT_SIZE / SEL_BIT; k++) begin
      r[k*SEL_BIT +: SEL_BIT] = SEL_BIT'(i);
    end
    return r;
  endfunction

  assign Mux_Out = mux_row(int'(Select));

  weight_row_sequencer dut (
    .Clk       (Clk),
    .Rst_n     (Rst_n),
    .Start     (Start),
    .Select    (Select),
    .Mux_Out   (Mux_Out),
    .Out_Data  (Out_Data),
    .Out_Index (Out_Index),
    .Out_Valid (Out_Valid),
    .Out_Ready (Out_Ready),
    .Out_Last  (Out_Last),
    .Busy      (Busy),
`ifdef WEIGHT_SEQ_LOOP_EN
    .Done      (Done),
    .Loop      (Loop)
`else
    .Done      (Done)
`endif
  );

  task automatic check(input string tag, input logic [OUT_SIZE-1:0] obs, input logic [OUT_SIZE-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard the current cycle, then advance to 1 time unit after the next rising edge.
  task automatic cycle();
    if (Out_Valid && Out_Ready) begin
      check("sb_index", Out_Index, exp_row);
      check("sb_data", Out_Data, mux_row(exp_row));
      check("sb_last", Out_Last, exp_row == SEL_SIZE - 1);
      exp_row++;
    end
    if (stall_prev) begin
      check("hold_valid", Out_Valid, 1);
      check("hold_data", Out_Data, held_data);
      check("hold_index", Out_Index, held_index);
    end
    stall_prev = Out_Valid && !Out_Ready;
    held_data  = Out_Data;
    held_index = Out_Index;
    check("sel_max", Select > 7'(SEL_SIZE - 1), 0);
    if (Done) done_cnt++;
    @(posedge Clk);
    #1;
    cyc++;
  endtask

  task automatic start_pass();
    cyc      = 0;
    exp_row  = 0;
    done_cnt = 0;
    Start    = 1'b1;
    cycle();
    Start    = 1'b0;
  endtask

  initial begin
    Rst_n      = 1'b0;
    Start      = 1'b0;
    Out_Ready  = 1'b0;
    stall_prev = 1'b0;
    exp_row    = 0;
    done_cnt   = 0;
    cyc        = 0;
`ifdef WEIGHT_SEQ_LOOP_EN
    Loop       = 1'b0;
`endif
    #12;
    check("rst_select", Select, 0);
    check("rst_data", Out_Data, 0);
    check("rst_index", Out_Index, 0);
    check("rst_valid", Out_Valid, 0);
    check("rst_last", Out_Last, 0);
    check("rst_busy", Busy, 0);
    check("rst_done", Done, 0);
    @(negedge Clk);
    Rst_n = 1'b1;
    @(posedge Clk);
    #1;

    // 1: full pass, ready always high
    Out_Ready = 1'b1;
    start_pass();
    check("t1_load_valid", Out_Valid, 0);
    check("t1_load_busy", Busy, 1);
    cycle();
    check("t1_lat_valid", Out_Valid, 1);
    check("t1_lat_index", Out_Index, 0);
    while (!Done && cyc < 400) cycle();
    check("t1_done_at", cyc, 114);
    check("t1_done_busy", Busy, 0);
    check("t1_rows", exp_row, SEL_SIZE);
    cycle();
    check("t1_done_pulse", Done, 0);
    check("t1_done_cnt", done_cnt, 1);
    check("t1_idle_busy", Busy, 0);

    // 2: random back-pressure
    Out_Ready = 1'($urandom_range(0, 1));
    start_pass();
    while (!Done && cyc < 2000) begin
      Out_Ready = 1'($urandom_range(0, 1));
      cycle();
    end
    check("t2_rows", exp_row, SEL_SIZE);
    Out_Ready = 1'b1;
    cycle();
    check("t2_done_cnt", done_cnt, 1);

    // 3: Start pulses while busy and on the Done cycle are ignored
    start_pass();
    while (!Done && cyc < 400) begin
      Start = Out_Valid && (Out_Index == 7'd10 || Out_Index == 7'd111);
      cycle();
    end
    Start = 1'b1;
    cycle();
    Start = 1'b0;
    repeat (5) begin
      check("t3_idle_busy", Busy, 0);
      check("t3_idle_valid", Out_Valid, 0);
      cycle();
    end
    check("t3_done_cnt", done_cnt, 1);
    check("t3_rows", exp_row, SEL_SIZE);

    // 4: asynchronous reset mid-pass
    start_pass();
    while (!(Out_Valid && Out_Index == 7'd57) && cyc < 400) cycle();
    check("t4_at57", Out_Index, 57);
    #2;
    Rst_n = 1'b0;
    #1;
    check("t4_rst_select", Select, 0);
    check("t4_rst_data", Out_Data, 0);
    check("t4_rst_index", Out_Index, 0);
    check("t4_rst_valid", Out_Valid, 0);
    check("t4_rst_last", Out_Last, 0);
    check("t4_rst_busy", Busy, 0);
    check("t4_rst_done", Done, 0);
    #2;
    Rst_n = 1'b1;
    stall_prev = 1'b0;
    @(posedge Clk);
    #1;
    repeat (3) begin
      check("t4_idle_busy", Busy, 0);
      check("t4_idle_done", Done, 0);
      cycle();
    end
    check("t4_no_done", done_cnt, 0);
    start_pass();
    cycle();
    check("t4_row0_valid", Out_Valid, 1);
    check("t4_row0_index", Out_Index, 0);
    check("t4_row0_data", Out_Data, mux_row(0));
    while (!Done && cyc < 400) cycle();
    check("t4_rows", exp_row, SEL_SIZE);
    cycle();

    // 5: long stall on the last row
    start_pass();
    while (!(Out_Valid && Out_Index == 7'd111) && cyc < 400) cycle();
    Out_Ready = 1'b0;
    repeat (20) begin
      check("t5_hold_valid", Out_Valid, 1);
      check("t5_hold_last", Out_Last, 1);
      check("t5_no_done", Done, 0);
      cycle();
    end
    Out_Ready = 1'b1;
    cycle();
    check("t5_done", Done, 1);
    check("t5_busy", Busy, 0);
    cycle();
    check("t5_rows", exp_row, SEL_SIZE);
    check("t5_done_cnt", done_cnt, 1);

`ifdef WEIGHT_SEQ_LOOP_EN
    // 6: Loop=1 restarts without IDLE, Loop=0 on the second pass ends it
    Loop = 1'b1;
    start_pass();
    while (!Done && cyc < 400) cycle();
    check("t6_done_at", cyc, 114);
    check("t6_busy", Busy, 1);
    check("t6_gap_valid", Out_Valid, 0);
    check("t6_rows", exp_row, SEL_SIZE);
    Loop    = 1'b0;
    exp_row = 0;
    cycle();
    check("t6_row0_valid", Out_Valid, 1);
    check("t6_row0_index", Out_Index, 0);
    check("t6_row0_busy", Busy, 1);
    while (!Done && cyc < 600) cycle();
    check("t6_rows2", exp_row, SEL_SIZE);
    check("t6_end_busy", Busy, 0);
    cycle();
    check("t6_done_cnt", done_cnt, 2);
    check("t6_idle_valid", Out_Valid, 0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
